vsync_conditioner: RTL and testbench
====================================

VSYNC_CONDITIONER -- requirements
Module: vsync_conditioner

Interface
REQ-001 Parameter FILTER_LEN, default 16: consecutive identical synchronized samples required to accept a level change (range 2..255).
REQ-002 Parameter LOCK_TIMEOUT, default 4000000: cycles without any filtered edge before lock is dropped (max 2^22-1).
REQ-003 clk_in  input  1  system clock; single clock domain.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 vsync_raw_in  input  1  raw VSYNC from the video decoder; asynchronous, either polarity, may glitch.
REQ-006 vsync_out  output  1  cleaned VSYNC, normalized to idle-high / pulse-low; the falling edge marks sync start; feeds the format detector vsync_in.
REQ-007 vsync_start_out  output  1  one-cycle strobe coincident with each vsync_out falling edge.
REQ-008 vsync_locked  output  1  high while polarity is known and edges keep arriving.
REQ-009 polarity_out  output  1  detected raw polarity: 1 = raw active-high, 0 = raw active-low; valid only while vsync_locked = 1.

Function
REQ-010 The block SHALL pass vsync_raw_in through a 2-flop synchronizer before any other use.
REQ-011 The glitch filter SHALL hold an 8-bit run counter and change its filtered level only after FILTER_LEN consecutive synchronized samples that differ from the current filtered level.
REQ-012 Any synchronized sample equal to the filtered level SHALL clear the run counter, so a pulse shorter than FILTER_LEN cycles is removed entirely.
REQ-013 vsync_out SHALL change exactly FILTER_LEN+2 clock edges after the first edge that samples a new, stable raw level.
REQ-014 The FSM SHALL have four states: WAIT_EDGE, MEAS_A, MEAS_B and LOCKED.
REQ-015 WAIT_EDGE: on any filtered edge the FSM SHALL record the new level as phaseA_level, clear the 22-bit phase counter and go to MEAS_A.
REQ-016 MEAS_A: the FSM SHALL count cycles; on the next filtered edge it SHALL store the count as lenA, clear the counter and go to MEAS_B.
REQ-017 MEAS_B: the FSM SHALL count cycles; on the next filtered edge it SHALL go to LOCKED with the active level set to the level of the shorter phase.
REQ-018 If lenA equals lenB, the active level SHALL be low.
REQ-019 In MEAS_A or MEAS_B, if the phase counter reaches 2^22-1 before an edge arrives, the FSM SHALL return to WAIT_EDGE with all measurements discarded.
REQ-020 LOCKED: the phase counter SHALL clear on every filtered edge.
REQ-021 LOCKED: when the phase counter reaches LOCK_TIMEOUT, the FSM SHALL return to WAIT_EDGE.
REQ-022 On the cycle the FSM leaves LOCKED, vsync_locked SHALL deassert.
REQ-023 vsync_out SHALL equal the registered inverse of (filtered level XNOR active level) in LOCKED, and SHALL be forced high in every other state.
REQ-024 The transition into LOCKED SHALL NOT produce a vsync_out falling edge or a vsync_start_out strobe; the first strobe comes on the next active-phase entry.
REQ-025 vsync_start_out SHALL assert for one cycle exactly when registered vsync_out goes 1->0.
REQ-026 Polarity SHALL NOT be re-evaluated while in LOCKED; a polarity change upstream is handled through the timeout or reset path only.

Reset
REQ-027 While rst_in is high at a clock edge, the block SHALL set: FSM = WAIT_EDGE; synchronizer flops, filtered level, run counter and phase counter = 0; vsync_out = 1; vsync_start_out = 0; vsync_locked = 0; polarity_out = 0.
REQ-028 Reset asserted mid-measurement or while locked SHALL take effect on the same edge, with no strobe emitted.
REQ-029 After reset the filtered level SHALL start at 0, so a raw input held high produces a filtered rising edge FILTER_LEN+2 edges after release; this edge counts as the WAIT_EDGE edge.

Configuration
REQ-030 With VSYNC_POLARITY_AUTO_EN defined, the block SHALL behave exactly as REQ-014 to REQ-019.
REQ-031 Without VSYNC_POLARITY_AUTO_EN, MEAS_A and MEAS_B SHALL NOT exist, the active level SHALL be fixed low with polarity_out = 0, and WAIT_EDGE SHALL go directly to LOCKED on the first filtered edge.
REQ-032 In both configurations the filter, the timeout and the output behaviour SHALL be identical.

Verification (FILTER_LEN=16, LOCK_TIMEOUT=5000 in the bench)
REQ-033 Active-low raw input, 100 cycles low / 1900 cycles high, repeated -> vsync_locked rises on the 3rd filtered edge; polarity_out=0; vsync_out falls 18 edges after each raw fall; vsync_start_out pulses each period.
REQ-034 Active-high raw input, 100 cycles high / 1900 cycles low -> polarity_out=1; vsync_out still pulses low for 100 cycles per period.
REQ-035 15-cycle glitches injected mid-phase -> no vsync_out change and lock retained; a 16-cycle pulse -> vsync_out toggles.
REQ-036 Lock established, then raw held constant -> vsync_locked drops exactly 5000 cycles after the last filtered edge; vsync_out held high.
REQ-037 rst_in pulsed for 1 cycle while in MEAS_B -> all outputs at reset values on the next cycle; relock occurs after 3 new filtered edges.
REQ-038 Macro undefined, active-low input -> lock on the 1st filtered edge; polarity_out stays 0.

Source files
------------

// File: rtl/vsync_conditioner.sv
// vsync_conditioner
//   Cleans a raw, asynchronous, possibly glitchy VSYNC from a video decoder.
//   The raw input is synchronized, run-length filtered, its polarity learned
//   from the relative lengths of the two phases, and re-emitted as an
//   idle-high / pulse-low VSYNC with a one-cycle start strobe.
//
//   Build option: define VSYNC_POLARITY_AUTO_EN to enable polarity learning
//   (MEAS_A / MEAS_B phase measurement). Without it, the raw input is taken
//   as active-low and the block locks on the first filtered edge.

module vsync_conditioner #(
    parameter int FILTER_LEN   = 16,
    parameter int LOCK_TIMEOUT = 4000000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic vsync_raw_in,
    output logic vsync_out,
    output logic vsync_start_out,
    output logic vsync_locked,
    output logic polarity_out
);

    // Filter flips when the run counter holds this value and another
    // differing sample arrives (FILTER_LEN differing samples in total).
    localparam logic [7:0]  RUN_LAST     = 8'(FILTER_LEN - 1);
    // Locked timeout: next count would reach LOCK_TIMEOUT.
    localparam logic [21:0] TIMEOUT_LAST = 22'(LOCK_TIMEOUT - 1);
    // Measurement overflow: next count would reach 2^22-1.
    localparam logic [21:0] PHASE_LAST   = 22'h3F_FFFE;

`ifdef VSYNC_POLARITY_AUTO_EN
    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        MEAS_A    = 2'd1,
        MEAS_B    = 2'd2,
        LOCKED    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        LOCKED    = 2'd3
    } state_t;
`endif

    // Synchronizer and glitch filter
    logic        sync_p0;
    logic        sync_p1;
    logic        filt_level;
    logic [7:0]  run_cnt;
    logic        filt_edge;

    // Lock FSM
    state_t      state;
    state_t      state_next;
    logic [21:0] phase_cnt;
    logic [21:0] phase_cnt_next;
    logic        act_level;

    // Output stage
    logic        out_next;
    logic        start_next;

`ifdef VSYNC_POLARITY_AUTO_EN
    logic        act_level_next;
    logic        phase_a_level;
    logic        phase_a_next;
    logic [21:0] len_a;
    logic [21:0] len_a_next;

    // The shorter phase is the sync pulse; a tie resolves to active-low.
    function automatic logic pick_active(input logic [21:0] len_first,
                                         input logic [21:0] len_second,
                                         input logic        level_first);
        logic act;
        if (len_first < len_second) begin
            act = level_first;
        end else if (len_second < len_first) begin
            act = ~level_first;
        end else begin
            act = 1'b0;
        end
        return act;
    endfunction
`endif

    // A filtered edge happens on the clock where the run counter completes.
    assign filt_edge = (sync_p1 != filt_level) && (run_cnt == RUN_LAST);

    // Two-flop synchronizer followed by the run-length glitch filter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            filt_level <= 1'b0;
            run_cnt    <= 8'd0;
        end else begin
            sync_p0 <= vsync_raw_in;
            sync_p1 <= sync_p0;
            if (sync_p1 == filt_level) begin
                run_cnt <= 8'd0;
            end else if (run_cnt == RUN_LAST) begin
                filt_level <= sync_p1;
                run_cnt    <= 8'd0;
            end else begin
                run_cnt <= run_cnt + 8'd1;
            end
        end
    end

    // Next-state logic of the lock FSM and its phase counter.
    always_comb begin
        state_next     = state;
        phase_cnt_next = phase_cnt + 22'd1;
`ifdef VSYNC_POLARITY_AUTO_EN
        act_level_next = act_level;
        phase_a_next   = phase_a_level;
        len_a_next     = len_a;
`endif
        case (state)
            WAIT_EDGE: begin
                phase_cnt_next = 22'd0;
                if (filt_edge) begin
`ifdef VSYNC_POLARITY_AUTO_EN
                    phase_a_next = sync_p1;
                    state_next   = MEAS_A;
`else
                    state_next   = LOCKED;
`endif
                end
            end
`ifdef VSYNC_POLARITY_AUTO_EN
            MEAS_A: begin
                if (filt_edge) begin
                    len_a_next     = phase_cnt;
                    phase_cnt_next = 22'd0;
                    state_next     = MEAS_B;
                end else if (phase_cnt == PHASE_LAST) begin
                    phase_cnt_next = 22'd0;
                    state_next     = WAIT_EDGE;
                end
            end
            MEAS_B: begin
                if (filt_edge) begin
                    act_level_next = pick_active(len_a, phase_cnt, phase_a_level);
                    phase_cnt_next = 22'd0;
                    state_next     = LOCKED;
                end else if (phase_cnt == PHASE_LAST) begin
                    phase_cnt_next = 22'd0;
                    state_next     = WAIT_EDGE;
                end
            end
`endif
            LOCKED: begin
                // Polarity is frozen here; only timeout or reset re-learns it.
                if (filt_edge) begin
                    phase_cnt_next = 22'd0;
                end else if (phase_cnt == TIMEOUT_LAST) begin
                    phase_cnt_next = 22'd0;
                    state_next     = WAIT_EDGE;
                end
            end
            default: begin
                phase_cnt_next = 22'd0;
                state_next     = WAIT_EDGE;
            end
        endcase
    end

    // State register and phase counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= WAIT_EDGE;
            phase_cnt <= 22'd0;
        end else begin
            state     <= state_next;
            phase_cnt <= phase_cnt_next;
        end
    end

`ifdef VSYNC_POLARITY_AUTO_EN
    // Learned active level; cleared by reset so polarity reads 0.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            act_level <= 1'b0;
        end else begin
            act_level <= act_level_next;
        end
    end

    // Measurement scratch registers, always rewritten before being used.
    always_ff @(posedge clk_in) begin
        phase_a_level <= phase_a_next;
        len_a         <= len_a_next;
    end

    assign polarity_out = act_level;
`else
    assign act_level    = 1'b0;
    assign polarity_out = 1'b0;
`endif

    assign vsync_locked = (state == LOCKED);

    // Output is forced high outside LOCKED and on the lock-entry cycle, then
    // toggles only on filtered edges, so locking never creates a false start.
    always_comb begin
        out_next = 1'b1;
        if ((state == LOCKED) && (state_next == LOCKED)) begin
            if (filt_edge) begin
                out_next = sync_p1 ^ act_level;
            end else begin
                out_next = vsync_out;
            end
        end
        start_next = vsync_out & ~out_next;
    end

    // Registered cleaned VSYNC and its falling-edge strobe.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vsync_out       <= 1'b1;
            vsync_start_out <= 1'b0;
        end else begin
            vsync_out       <= out_next;
            vsync_start_out <= start_next;
        end
    end

endmodule

// File: tb/tb_vsync_conditioner.sv
// Testbench for vsync_conditioner (FILTER_LEN=16, LOCK_TIMEOUT=5000).
// Output events (vsync_out change, start strobe, lock change) are predicted
// with their clock-edge number when stimulus is driven, queued, and matched
// against what the DUT produces.

`timescale 1ns/1ps

module tb_vsync_conditioner;

    localparam int FILTER_LEN = 16;
    localparam int TIMEOUT    = 5000;
`ifdef VSYNC_POLARITY_AUTO_EN
    localparam int LOCK_EDGES = 3;
    localparam bit AUTO       = 1'b1;
`else
    localparam int LOCK_EDGES = 1;
    localparam bit AUTO       = 1'b0;
`endif

    localparam int K_OUT   = 0;
    localparam int K_START = 1;
    localparam int K_LOCK  = 2;

    typedef struct {
        int at;
        int kind;
        bit val;
    } ev_t;

    logic clk;
    logic rst;
    logic raw;
    logic vsync_out;
    logic vsync_start_out;
    logic vsync_locked;
    logic polarity_out;

    ev_t  exp_q[$];
    int   edge_no = 0;
    bit   mon_en  = 1'b0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    // Event-level expectation of the DUT
    bit   m_filt      = 1'b0;
    bit   m_out       = 1'b1;
    bit   m_locked    = 1'b0;
    bit   m_act       = 1'b0;
    int   m_edges     = 0;
    int   m_last_edge = 0;

    vsync_conditioner #(
        .FILTER_LEN  (FILTER_LEN),
        .LOCK_TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .vsync_raw_in   (raw),
        .vsync_out      (vsync_out),
        .vsync_start_out(vsync_start_out),
        .vsync_locked   (vsync_locked),
        .polarity_out   (polarity_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string kname(input int k);
        if (k == K_OUT)   return "vsync_out";
        if (k == K_START) return "vsync_start";
        return "vsync_locked";
    endfunction

    task automatic push_ev(input int at, input int kind, input bit val);
        ev_t ev;
        ev.at   = at;
        ev.kind = kind;
        ev.val  = val;
        exp_q.push_back(ev);
    endtask

    task automatic model_timeout();
        int d;
        d = m_last_edge + TIMEOUT;
        if (m_out == 1'b0) push_ev(d, K_OUT, 1'b1);
        push_ev(d, K_LOCK, 1'b0);
        m_out    = 1'b1;
        m_locked = 1'b0;
        m_edges  = 0;
    endtask

    task automatic model_edge(input int e, input bit lvl);
        bit new_out;
        if (m_locked && (m_last_edge + TIMEOUT < e)) model_timeout();
        m_filt      = lvl;
        m_last_edge = e;
        if (m_locked) begin
            new_out = (lvl == m_act) ? 1'b0 : 1'b1;
            if (new_out != m_out) begin
                push_ev(e, K_OUT, new_out);
                if (new_out == 1'b0) push_ev(e, K_START, 1'b1);
            end
            m_out = new_out;
        end else begin
            m_edges++;
            if (m_edges == LOCK_EDGES) begin
                m_locked = 1'b1;
                push_ev(e, K_LOCK, 1'b1);
            end
        end
    endtask

    // Advance to the next negedge; predict a lock timeout due on the next edge.
    task automatic tick();
        @(negedge clk);
        if (m_locked && (edge_no + 1 == m_last_edge + TIMEOUT)) model_timeout();
    endtask

    task automatic apply_raw(input bit lvl, input int hold);
        raw = lvl;
        if ((lvl != m_filt) && (hold >= FILTER_LEN))
            model_edge(edge_no + FILTER_LEN + 2, lvl);
        repeat (hold) tick();
    endtask

    task automatic do_reset(input int cycles);
        if (m_out == 1'b0) push_ev(edge_no + 1, K_OUT, 1'b1);
        if (m_locked)      push_ev(edge_no + 1, K_LOCK, 1'b0);
        m_out    = 1'b1;
        m_locked = 1'b0;
        m_edges  = 0;
        m_filt   = 1'b0;
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
        if (raw == 1'b1) model_edge(edge_no + FILTER_LEN + 2, 1'b1);
    endtask

    // Scoreboard monitor: samples 1 time unit after each rising edge.
    initial begin
        bit   has  [3];
        bit   vals [3];
        bit   prev_out;
        bit   prev_lock;
        ev_t  ev;
        prev_out  = 1'b1;
        prev_lock = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            if (mon_en) begin
                while ((exp_q.size() > 0) && (exp_q[0].at < edge_no)) begin
                    ev = exp_q.pop_front();
                    n_cmp++;
                    n_fail++;
                    $display("FAIL missing_%s: no change to %0b seen, required at edge %0d", kname(ev.kind), ev.val, ev.at);
                end
                has[K_OUT]    = (vsync_out !== prev_out);
                vals[K_OUT]   = vsync_out;
                has[K_START]  = (vsync_start_out === 1'b1);
                vals[K_START] = 1'b1;
                has[K_LOCK]   = (vsync_locked !== prev_lock);
                vals[K_LOCK]  = vsync_locked;
                for (int k = 0; k < 3; k++) begin
                    if (has[k]) begin
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_%s: got %0b at edge %0d, required no change", kname(k), vals[k], edge_no);
                        end else begin
                            ev = exp_q.pop_front();
                            if ((ev.at !== edge_no) || (ev.kind !== k) || (ev.val !== vals[k])) begin
                                n_fail++;
                                $display("FAIL event: got %s=%0b at edge %0d, required %s=%0b at edge %0d",
                                         kname(k), vals[k], edge_no, kname(ev.kind), ev.val, ev.at);
                            end
                        end
                    end
                end
            end
            prev_out  = vsync_out;
            prev_lock = vsync_locked;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        raw = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (vsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_out: got %0b required 1", vsync_out); end
        n_cmp++;
        if (vsync_start_out !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0b required 0", vsync_start_out); end
        n_cmp++;
        if (vsync_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b required 0", vsync_locked); end
        n_cmp++;
        if (polarity_out !== 1'b0) begin n_fail++; $display("FAIL reset_polarity: got %0b required 0", polarity_out); end
        mon_en = 1'b1;
    endtask

    task automatic test_active_low();
        m_act = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply_raw(1'b1, 1900);
            apply_raw(1'b0, 100);
        end
        apply_raw(1'b1, 1900);
        n_cmp++;
        if (vsync_locked !== 1'b1) begin n_fail++; $display("FAIL low_locked: got %0b required 1", vsync_locked); end
        n_cmp++;
        if (polarity_out !== 1'b0) begin n_fail++; $display("FAIL low_polarity: got %0b required 0", polarity_out); end
    endtask

    task automatic test_active_high();
        m_act = AUTO;
        do_reset(1);
        apply_raw(1'b1, 100);
        for (int i = 0; i < 4; i++) begin
            apply_raw(1'b0, 1900);
            apply_raw(1'b1, 100);
        end
        apply_raw(1'b0, 1900);
        n_cmp++;
        if (vsync_locked !== 1'b1) begin n_fail++; $display("FAIL high_locked: got %0b required 1", vsync_locked); end
        n_cmp++;
        if (polarity_out !== AUTO) begin n_fail++; $display("FAIL high_polarity: got %0b required %0b", polarity_out, AUTO); end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 2; i++) begin
            apply_raw(1'b1, FILTER_LEN - 1);
            apply_raw(1'b0, 500);
        end
        n_cmp++;
        if (vsync_locked !== 1'b1) begin n_fail++; $display("FAIL glitch_locked: got %0b required 1", vsync_locked); end
        apply_raw(1'b1, FILTER_LEN);
        apply_raw(1'b0, 500);
        n_cmp++;
        if (vsync_locked !== 1'b1) begin n_fail++; $display("FAIL pulse16_locked: got %0b required 1", vsync_locked); end
    endtask

    task automatic test_timeout();
        apply_raw(1'b0, TIMEOUT + 100);
        n_cmp++;
        if (vsync_locked !== 1'b0) begin n_fail++; $display("FAIL timeout_locked: got %0b required 0", vsync_locked); end
        n_cmp++;
        if (vsync_out !== 1'b1) begin n_fail++; $display("FAIL timeout_out: got %0b required 1", vsync_out); end
    endtask

    task automatic test_reset_meas_b();
        m_act = 1'b0;
        apply_raw(1'b1, 300);
        apply_raw(1'b0, 100);
        do_reset(1);
        n_cmp++;
        if (vsync_out !== 1'b1) begin n_fail++; $display("FAIL midreset_out: got %0b required 1", vsync_out); end
        n_cmp++;
        if (vsync_start_out !== 1'b0) begin n_fail++; $display("FAIL midreset_start: got %0b required 0", vsync_start_out); end
        n_cmp++;
        if (vsync_locked !== 1'b0) begin n_fail++; $display("FAIL midreset_locked: got %0b required 0", vsync_locked); end
        n_cmp++;
        if (polarity_out !== 1'b0) begin n_fail++; $display("FAIL midreset_polarity: got %0b required 0", polarity_out); end
        apply_raw(1'b1, 200);
        apply_raw(1'b0, 100);
        apply_raw(1'b1, 200);
        apply_raw(1'b0, 100);
        apply_raw(1'b1, 300);
        n_cmp++;
        if (vsync_locked !== 1'b1) begin n_fail++; $display("FAIL relock_locked: got %0b required 1", vsync_locked); end
        n_cmp++;
        if (polarity_out !== 1'b0) begin n_fail++; $display("FAIL relock_polarity: got %0b required 0", polarity_out); end
    endtask

    initial begin
        rst = 1'b1;
        raw = 1'b0;
        test_reset();
        test_active_low();
        test_active_high();
        test_glitch();
        test_timeout();
        test_reset_meas_b();
        repeat (40) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d outstanding required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time bound for the whole run.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion before %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
